// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift/compare ops plus
// an iterative radix-2 shift-add multiply, with a registered result.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] source1,
    input  logic [WIDTH-1:0] source2,
    input  logic [3:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL = 4'b1001;

    state_t           state, state_nxt;
    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;

    function automatic logic [WIDTH-1:0] alu_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [SHW-1:0]          sh;
        a_s = $signed(a);
        b_s = $signed(b);
        sh  = b[SHW-1:0];
        case (op)
            4'b0000: alu_op = a + b;
            4'b1000: alu_op = a - b;
            4'b0001: alu_op = a << sh;
            4'b0010: alu_op = WIDTH'(a_s < b_s);
            4'b0011: alu_op = WIDTH'(a < b);
            4'b0100: alu_op = a ^ b;
            4'b0101: alu_op = a >> sh;
            4'b1101: alu_op = $unsigned(a_s >>> sh);
            4'b0110: alu_op = a | b;
            4'b0111: alu_op = a & b;
            default: alu_op = '0;
        endcase
    endfunction

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (oper == OP_MUL);
    assign mul_last  = (state == MUL) && (cnt == SHW'(WIDTH - 1));
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
    assign op_res    = alu_op(oper, source1, source2);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = accept ? (is_mul ? MUL : DONE) : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result register and multiply datapath; one multiplier bit retired per MUL cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res    <= '0;
            zero   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= source1;
                mplier <= source2;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                res  <= op_res;
                zero <= (op_res == '0);
            end
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (mul_last) begin
                res  <= acc_nxt;
                zero <= (acc_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, multiply timing, backpressure,
// mid-multiply reset and randomized ops against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] source1 = '0;
    logic [31:0] source2 = '0;
    logic [3:0]  oper = '0;
    logic        in_ready;
    logic        out_valid;
    logic        zero;
    logic        busy;
    logic [31:0] res;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t tbl [12] = '{
        '{4'b0000, 32'd5,        32'd7,        32'd12},
        '{4'b0111, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0},
        '{4'b1000, 32'd3,        32'd5,        32'hFFFFFFFE},
        '{4'b1000, 32'd9,        32'd9,        32'h00000000},
        '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1},
        '{4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0},
        '{4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000},
        '{4'b0101, 32'h80000000, 32'h00000024, 32'h08000000},
        '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000},
        '{4'b0001, 32'h00000001, 32'h00000021, 32'h00000002},
        '{4'b0101, 32'hCAFEBABE, 32'hFFFFFFE0, 32'hCAFEBABE},
        '{4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F}
    };

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .source1   (source1),
        .source2   (source2),
        .oper      (oper),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: results defined by integer arithmetic on the operand values.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, p, q;
        logic [63:0] t;
        int          sh;
        sh = int'(b % 32);
        p  = longint'(1) << sh;
        sa = a[31] ? (longint'(a) - 64'sd4294967296) : longint'(a);
        sb = b[31] ? (longint'(b) - 64'sd4294967296) : longint'(b);
        t  = '0;
        case (op)
            4'b0000: t = longint'(a) + longint'(b);
            4'b1000: t = longint'(a) - longint'(b);
            4'b0001: t = longint'(a) * p;
            4'b0010: t = (sa < sb) ? 64'd1 : 64'd0;
            4'b0011: t = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            4'b0100: t = {32'b0, a ^ b};
            4'b0101: t = longint'(a) / p;
            4'b1101: begin
                q = sa / p;
                if (sa < 0 && q * p != sa) q = q - 1;
                t = q;
            end
            4'b0110: t = {32'b0, a | b};
            4'b0111: t = {32'b0, a & b};
            4'b1001: t = {32'b0, a} * {32'b0, b};
            default: t = '0;
        endcase
        return t[31:0];
    endfunction

    // Presents one op, waits for acceptance, then counts cycles until out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit timeout);
        int w;
        timeout  = 1'b0;
        oper     = op;
        source1  = a;
        source2  = b;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) timeout = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        source1  = $urandom;
        source2  = $urandom;
        oper     = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, zero, busy, in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags got ov/z/busy/rdy=%b required=0001",
                     {out_valid, zero, busy, in_ready});
        end
        checks++;
        if (res !== 32'h0) begin
            failures++;
            $display("FAIL reset_res got=%h required=00000000", res);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, to);
            checks++;
            if (to || lat != 0) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d timeout=%0b required=0", i, lat, to);
            end
            checks++;
            if (res !== tbl[i].e) begin
                failures++;
                $display("FAIL directed_res[%0d] op=%b got=%h required=%h", i, tbl[i].op, res, tbl[i].e);
            end
            checks++;
            if (zero !== (tbl[i].e == 32'h0)) begin
                failures++;
                $display("FAIL directed_zero[%0d] got=%b required=%b", i, zero, (tbl[i].e == 32'h0));
            end
        end
    endtask

    task automatic test_mul_timing();
        out_ready = 1'b1;
        oper      = 4'b1001;
        source1   = 32'hFFFFFFFF;
        source2   = 32'd3;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_accept_ready got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        source1  = $urandom;
        source2  = $urandom;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                failures++;
                $display("FAIL mul_busy cycle=%0d got busy/rdy/ov=%b required=100", i,
                         {busy, in_ready, out_valid});
            end
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if ({busy, out_valid} !== 2'b01) begin
            failures++;
            $display("FAIL mul_done_flags got busy/ov=%b required=01", {busy, out_valid});
        end
        checks++;
        if (res !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL mul_res got=%h required=fffffffd", res);
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        bit          to;
        logic [31:0] a, b, x, y, e;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; x = $urandom; y = $urandom;
        e = a + b;
        out_ready = 1'b0;
        issue(4'b0000, a, b, lat, to);
        checks++;
        if (to || lat != 0) begin
            failures++;
            $display("FAIL bp_add_latency got=%0d timeout=%0b required=0", lat, to);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || res !== e || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got ov=%b rdy=%b res=%h required ov=1 rdy=0 res=%h",
                         i, out_valid, in_ready, res, e);
            end
            @(posedge clk); #1;
        end
        oper = 4'b0100; source1 = x; source2 = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || res !== (x ^ y)) begin
            failures++;
            $display("FAIL bp_xor got ov=%b res=%h required ov=1 res=%h", out_valid, res, x ^ y);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_duplicate got ov=%b required=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        bit to;
        out_ready = 1'b1;
        @(posedge clk); #1;
        oper = 4'b1001; source1 = $urandom; source2 = $urandom;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmul_busy_before got=%b required=1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, in_ready, zero} !== 4'b0010 || res !== 32'h0) begin
            failures++;
            $display("FAIL rstmul_state got ov/busy/rdy/z=%b res=%h required 0010 res=00000000",
                     {out_valid, busy, in_ready, zero}, res);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        issue(4'b0000, 32'd1, 32'd1, lat, to);
        checks++;
        if (to || lat != 0 || res !== 32'd2) begin
            failures++;
            $display("FAIL rstmul_add got res=%h lat=%0d timeout=%0b required res=00000002 lat=0",
                     res, lat, to);
        end
    endtask

    task automatic test_random();
        int          lat, n;
        bit          to;
        logic [3:0]  op;
        logic [31:0] a, b, e;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            e  = model(op, a, b);
            out_ready = 1'b1;
            issue(op, a, b, lat, to);
            checks++;
            if (to || lat != ((op == 4'b1001) ? 32 : 0)) begin
                failures++;
                $display("FAIL rand_latency[%0d] op=%b got=%0d timeout=%0b", i, op, lat, to);
            end
            checks++;
            if (res !== e || zero !== (e == 32'h0)) begin
                failures++;
                $display("FAIL rand_res[%0d] op=%b a=%h b=%h got=%h z=%b required=%h z=%b",
                         i, op, a, b, res, zero, e, (e == 32'h0));
            end
            n = $urandom_range(0, 2);
            if (n > 0) begin
                out_ready = 1'b0;
                repeat (n) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || res !== e) begin
                        failures++;
                        $display("FAIL rand_hold[%0d] got ov=%b res=%h required ov=1 res=%h",
                                 i, out_valid, res, e);
                    end
                end
                out_ready = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_timing();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU in the CPU datapath.
- Width is generic, the opcode is widened to a 4-bit RV-style {alt, funct3} field, and shifts, compares, sub and an iterative multiply are added.
- Operations are accepted via valid/ready and results are returned registered, so the CPU control unit can stall on multi-cycle ops.
- The legacy 3-bit encodings (000 add, 100 xor, 110 or, 111 and) keep their meaning when alt=0.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- source1  input  WIDTH  first operand.
- source2  input  WIDTH  second operand; low SHW bits are the shift amount.
- oper  input  4  opcode {alt, funct3}.
- out_valid  output  1  res valid.
- out_ready  input  1  consumer takes res this cycle.
- res  output  WIDTH  result.
- zero  output  1  res == 0, registered with res.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, res=0, zero=0, busy=0, in_ready=1. Any in-flight multiply is discarded.
- States:
  - IDLE: waiting for an op.
  - MUL: iterating a multiply.
  - DONE: holding a result.
- Accept: in_valid && in_ready at a rising edge. Operands and opcode are captured at that edge; inputs are don't-care afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back issue is allowed when the result is consumed in the same cycle.
- Opcode map:
  - 0000 add
  - 1000 sub (source1 - source2)
  - 0001 sll
  - 0010 slt (signed, result 1/0)
  - 0011 sltu (unsigned, result 1/0)
  - 0100 xor
  - 0101 srl
  - 1101 sra (arithmetic)
  - 0110 or
  - 0111 and
  - 1001 mul (low WIDTH bits of the product)
  - All other codes: res=0, 1-cycle latency.
- Arithmetic: add/sub wrap modulo 2^WIDTH, no carry/overflow output. Shift amount = source2[SHW-1:0], upper bits ignored; shift by 0 returns source1.
- Single-cycle ops: accepted at edge k → res, zero and out_valid=1 registered at edge k; visible from cycle k+1. State goes to DONE.
- mul: accepted at edge k → state MUL, busy=1.
  - Radix-2 shift-add, one multiplier bit per cycle, WIDTH iterations.
  - At edge k+WIDTH: res = product, out_valid=1, busy=0, state DONE.
  - in_ready=0 throughout MUL.
- DONE: res/zero/out_valid are held stable while out_ready=0.
  - out_ready=1 && in_valid=0 → IDLE, out_valid=0 next edge.
  - out_ready=1 && in_valid=1 → new op accepted on the same edge; res updates (single-cycle op) or state becomes MUL with out_valid=0 (mul).
- out_ready in IDLE/MUL is ignored.
- zero is always consistent with the currently held res.

Test Plan:
- Reset then add 5+7 (oper 0000) with out_ready=1 → out_valid=1 one cycle after accept, res=12, zero=0; legacy and 0xF0F0&0x0FF0 → 0x00F0.
- sub 3-5 → 0xFFFFFFFE; sub 9-9 → res=0, zero=1; slt 0xFFFFFFFF,1 → 1; sltu same operands → 0.
- sra 0x80000000 by source2=0x24 (amount 4) → 0xF8000000; srl same → 0x08000000; unused oper 1111 → res=0 after 1 cycle.
- mul 0xFFFFFFFF×3 → busy=1 and in_ready=0 for 32 cycles, then res=0xFFFFFFFD, out_valid=1 exactly 32 cycles after accept.
- Backpressure: out_ready=0 for 5 cycles after an add → res and out_valid held, in_ready=0. Then out_ready=1 with a new xor pending → xor accepted on the same edge, next res correct, no lost or duplicated result.
- Assert rst at mul cycle 10 → out_valid=0, busy=0, in_ready=1 immediately. A following add 1+1 returns 2 with normal 1-cycle latency.
